imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Write-side counterpart of the instruction ROM: boot loader that fills a writable
//  instruction memory from a byte stream (e.g. UART RX) before the core runs.
//  Holds the processor in reset until the image is fully written, then releases it.
//  Sits between the byte source and the write port of the instruction RAM.
//  Stream format: one count byte C (1..DEPTH), then 4*C bytes, little-endian words.
// PARAMETERS
//  N       32  instruction word width (fixed at 4 bytes per word)
//  ADDR_W  6   instruction address width (word address)
//  DEPTH   64  words in instruction memory; max legal C
// PORTS
//  clk        in   1       system clock
//  reset      in   1       asynchronous, active-low reset
//  in_data    in   8       stream byte
//  in_valid   in   1       in_data valid
//  in_ready   out  1       loader accepts byte; transfer when in_valid & in_ready
//  we         out  1       instruction RAM write enable, one-cycle pulse per word
//  waddr      out  ADDR_W  word address of write
//  wdata      out  N       word to write
//  cpu_rst_n  out  1       processor reset, low until load completes
//  done       out  1       image loaded, sticky
//  error      out  1       illegal count byte, sticky
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, in_ready=0 during reset then 1 in IDLE,
//    we=0, waddr=0, wdata=0, cpu_rst_n=0, done=0, error=0, counters=0.
//  - IDLE: in_ready=1. Accepted byte b: b==0 or b>DEPTH -> ERROR; else count<=b,
//    word_idx<=0, byte_idx<=0 -> RECV.
//  - RECV: in_ready=1. Accepted byte goes to wdata[8*byte_idx +: 8]; byte_idx++.
//    Accepting byte_idx==3 -> WRITE. No transfer -> hold state/data.
//  - WRITE: exactly one cycle; we=1, waddr=word_idx, wdata complete; in_ready=0.
//    Then word_idx==count-1 -> DONE; else word_idx++, byte_idx<=0 -> RECV.
//  - Latency: we high in the cycle after the 4th byte of a word is accepted.
//    Throughput: max 1 word per 5 cycles with continuous in_valid.
//  - DONE: done=1, cpu_rst_n=1, in_ready=0, we=0; extra bytes ignored; exit only by reset.
//  - ERROR: error=1, cpu_rst_n=0, in_ready=0, we=0; exit only by reset.
//  - done and error never both 1. we never asserted outside WRITE.
//  - word_idx is ADDR_W+1 bits wide so count==DEPTH (last waddr=DEPTH-1) is legal.
//  - Reset mid-load: back to IDLE, partial word discarded; words already written
//    stay in RAM (loader never clears memory); unwritten addresses untouched.
//  - in_valid held high while in_ready=0: byte not consumed; accepted on next ready.
// STRUCTURE
//  - Package imem_loader_pkg: state enum {IDLE,RECV,WRITE,DONE,ERROR},
//    BYTES_PER_WORD=4, DEPTH, ADDR_W.
//  - One sub-module natural: word_assembler (byte_idx counter + 4x8 shift/insert
//    into N-bit word, word_full flag); FSM and address counter stay in imem_loader.
// TESTING
//  1. Bytes 02, 02 00 00 8b, 03 00 00 8b -> we at waddr 0 wdata 32'h8b000002, then
//     waddr 1 wdata 32'h8b000003; then done=1, cpu_rst_n=1, in_ready=0.
//  2. Count byte 00 -> error=1, cpu_rst_n=0, no we pulse; 65 (8'h41) -> same.
//  3. Count 64, 256 payload bytes -> 64 we pulses, waddr 0..63 in order, then done=1.
//  4. in_valid held high continuously, 1-word image -> in_ready=0 during WRITE cycle,
//     no byte dropped or duplicated; data gaps (in_valid=0 mid-word) -> word intact.
//  5. Reset asserted after 2 payload bytes -> all outputs to reset values immediately;
//     fresh load 01, de ad be ef -> wdata 32'hefbeadde at waddr 0, done=1.
//  6. After done, drive 10 more bytes with in_valid=1 -> no we, outputs unchanged.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction memory boot loader
package imem_loader_pkg;

  localparam int N              = 32;
  localparam int ADDR_W         = 6;
  localparam int DEPTH          = 64;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERROR} state_t;

  // One extra bit so a full image (count == DEPTH) is representable.
  typedef logic [ADDR_W:0] word_idx_t;

  function automatic logic count_legal(input logic [7:0] c);
    return (c != 8'd0) && (c <= DEPTH_B);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in, instruction RAM write port out
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [N-1:0]      wdata;

  modport master (output in_data, in_valid, input in_ready, we, waddr, wdata);
  modport slave  (input in_data, in_valid, output in_ready, we, waddr, wdata);

endinterface

// File: rtl/imem_loader_word_assembler.sv
// rtl/imem_loader_word_assembler.sv - packs little-endian bytes into one instruction word
module imem_loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         byte_valid_i,
  input  logic [7:0]   byte_i,
  output logic [N-1:0] word_o,
  output logic         word_full_o
);

  logic [1:0]   byte_idx_q, byte_idx_d;
  logic [N-1:0] word_q, word_d;

  always_comb begin
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    if (clear_i) begin
      byte_idx_d = '0;
    end else if (byte_valid_i) begin
      word_d[8*byte_idx_q +: 8] = byte_i;
      byte_idx_d                = byte_idx_q + 2'd1;
    end
  end

  // Flags the accept that completes the word; the index wraps to 0 on its own.
  assign word_full_o = byte_valid_i && !clear_i &&
                       (byte_idx_q == 2'(BYTES_PER_WORD - 1));
  assign word_o      = word_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byte_idx_q <= '0;
      word_q     <= '0;
    end else begin
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader: count byte + 4*count payload bytes into instruction RAM
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  imem_loader_if.slave bus,
  output logic         cpu_rst_no,
  output logic         done_o,
  output logic         error_o
);

  state_t            state_q, state_d;
  logic [7:0]        count_q, count_d;
  word_idx_t         word_idx_q, word_idx_d;
  logic              in_ready_q, in_ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              accept;
  logic              asm_clear;
  logic              word_full;
  logic [N-1:0]      word;

  assign accept = bus.in_valid && in_ready_q;

  imem_loader_word_assembler u_asm (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (asm_clear),
    .byte_valid_i (accept && (state_q == RECV)),
    .byte_i       (bus.in_data),
    .word_o       (word),
    .word_full_o  (word_full)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      count_q     <= '0;
      word_idx_q  <= '0;
      in_ready_q  <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      cpu_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      word_idx_q  <= word_idx_d;
      in_ready_q  <= in_ready_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    asm_clear  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (count_legal(bus.in_data)) begin
            count_d    = bus.in_data;
            word_idx_d = '0;
            asm_clear  = 1'b1;
            state_d    = RECV;
          end else begin
            state_d = ERROR;
          end
        end
      end
      RECV: begin
        if (word_full) state_d = WRITE;
      end
      WRITE: begin
        if (8'(word_idx_q) == count_q - 8'd1) begin
          state_d = DONE;
        end else begin
          word_idx_d = word_idx_q + word_idx_t'(1);
          state_d    = RECV;
        end
      end
      default: state_d = state_q;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    in_ready_d  = (state_d == IDLE) || (state_d == RECV);
    we_d        = (state_d == WRITE);
    waddr_d     = (state_d == WRITE) ? word_idx_q[ADDR_W-1:0] : waddr_q;
    cpu_rst_n_d = (state_d == DONE);
    done_d      = (state_d == DONE);
    error_d     = (state_d == ERROR);
  end

  assign bus.in_ready = in_ready_q;
  assign bus.we       = we_q;
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = word;
  assign cpu_rst_no   = cpu_rst_n_q;
  assign done_o       = done_q;
  assign error_o      = error_q;

endmodule
